// File: rtl/xspi_req_arbiter_if.sv
// Two-requester xSPI arbiter bus: request/response handshakes
// plus the single-transaction controller port.
interface xspi_req_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_command;
  logic [47:0] req0_address;
  logic [63:0] req0_wr_data;

  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_command;
  logic [47:0] req1_address;
  logic [63:0] req1_wr_data;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [63:0] rsp0_rd_data;
  logic        rsp0_err;

  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [63:0] rsp1_rd_data;
  logic        rsp1_err;

  logic        xspi_start;
  logic [7:0]  xspi_command;
  logic [47:0] xspi_address;
  logic [63:0] xspi_wr_data;
  logic [63:0] xspi_rd_data;
  logic        xspi_done;

  // arbiter side
  modport slave (
    input  req0_valid, req0_command,
    input  req0_address, req0_wr_data,
    output req0_ready,
    input  req1_valid, req1_command,
    input  req1_address, req1_wr_data,
    output req1_ready,
    output rsp0_valid, rsp0_rd_data, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_rd_data, rsp1_err,
    input  rsp1_ready,
    output xspi_start, xspi_command,
    output xspi_address, xspi_wr_data,
    input  xspi_rd_data, xspi_done
  );

  // requesters and controller side
  modport master (
    output req0_valid, req0_command,
    output req0_address, req0_wr_data,
    input  req0_ready,
    output req1_valid, req1_command,
    output req1_address, req1_wr_data,
    input  req1_ready,
    input  rsp0_valid, rsp0_rd_data, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_rd_data, rsp1_err,
    output rsp1_ready,
    input  xspi_start, xspi_command,
    input  xspi_address, xspi_wr_data,
    output xspi_rd_data, xspi_done
  );
endinterface

// File: rtl/xspi_req_arbiter.sv
// Round-robin arbiter feeding one xSPI controller from two requesters.
// Optional WAIT timeout enabled by defining XSPI_ARB_TIMEOUT_EN.
module xspi_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xspi_req_arbiter_if.slave    bus,
  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              grant;
  logic              accept;
  logic              rsp_ready_g;

  logic [7:0]        cmd_q;
  logic [47:0]       addr_q;
  logic [63:0]       wdata_q;
  logic              start_q;

  logic [1:0]        rsp_valid;
  logic [1:0][63:0]  rsp_data;

`ifdef XSPI_ARB_TIMEOUT_EN
  logic [1:0]        rsp_err;
  logic [15:0]       wait_cnt;
  logic              to_hit;
`endif

  // winner selection: lone requester wins, ties alternate
  always_comb begin
    grant  = bus.req1_valid;
    if (bus.req0_valid & bus.req1_valid)
      grant = ~last_grant;
    accept = (state == IDLE) &
             (bus.req0_valid | bus.req1_valid);
    rsp_ready_g = owner ? bus.rsp1_ready
                        : bus.rsp0_ready;
  end

  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  assign busy = (state != IDLE);

  assign bus.xspi_start   = start_q;
  assign bus.xspi_command = cmd_q;
  assign bus.xspi_address = addr_q;
  assign bus.xspi_wr_data = wdata_q;

  assign bus.rsp0_valid   = rsp_valid[0];
  assign bus.rsp1_valid   = rsp_valid[1];
  assign bus.rsp0_rd_data = rsp_data[0];
  assign bus.rsp1_rd_data = rsp_data[1];

`ifdef XSPI_ARB_TIMEOUT_EN
  assign bus.rsp0_err = rsp_err[0];
  assign bus.rsp1_err = rsp_err[1];
  assign to_hit = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter, cleared while issuing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (state == ISSUE)
      wait_cnt <= '0;
    else if (state == WAIT)
      wait_cnt <= wait_cnt + 16'd1;
  end
`else
  assign bus.rsp0_err = 1'b0;
  assign bus.rsp1_err = 1'b0;
`endif

  // transaction FSM with registered controller/response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
`ifdef XSPI_ARB_TIMEOUT_EN
      rsp_err    <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (grant) begin
              cmd_q   <= bus.req1_command;
              addr_q  <= bus.req1_address;
              wdata_q <= bus.req1_wr_data;
            end else begin
              cmd_q   <= bus.req0_command;
              addr_q  <= bus.req0_address;
              wdata_q <= bus.req0_wr_data;
            end
            owner      <= grant;
            last_grant <= grant;
            start_q    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.xspi_done) begin
            rsp_valid[owner] <= 1'b1;
            rsp_data[owner]  <= bus.xspi_rd_data;
`ifdef XSPI_ARB_TIMEOUT_EN
            rsp_err[owner]   <= 1'b0;
`endif
            state <= RESP;
          end
`ifdef XSPI_ARB_TIMEOUT_EN
          else if (to_hit) begin
            rsp_valid[owner] <= 1'b1;
            rsp_data[owner]  <= '0;
            rsp_err[owner]   <= 1'b1;
            state <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_g) begin
            rsp_valid[owner] <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xspi_req_arbiter.sv
// Randomized bench for xspi_req_arbiter with a transaction-level model.
// Follows XSPI_ARB_TIMEOUT_EN when it is defined for the build.
module tb_xspi_req_arbiter;

  localparam int TO = 8;
`ifdef XSPI_ARB_TIMEOUT_EN
  localparam int RD_DLY = 5;
`else
  localparam int RD_DLY = 20;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  logic owner;

  xspi_req_arbiter_if bus();

  xspi_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int n_start = 0;
  bit rdy0_s, rdy1_s;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One transaction in flight at most. It is described by the
  // period it was issued in (m_tacc); the controller is waited on
  // from the following period until done or the timeout budget.
  longint      cyc;
  bit          m_act;
  bit          m_resp;
  bit          m_g;
  longint      m_tacc;
  bit          m_last;
  bit          m_own;
  logic [7:0]  m_cmd;
  logic [47:0] m_addr;
  logic [63:0] m_wd;
  logic [63:0] m_rd [2];
  bit          m_rv [2];
  bit          m_err [2];

  function automatic bit win();
    if (bus.req0_valid && bus.req1_valid) return !m_last;
    return bus.req1_valid ? 1'b1 : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit g;
    if (!rst_n) begin
      m_act  <= 0;
      m_resp <= 0;
      m_last <= 1;
      m_own  <= 0;
      m_cmd  <= '0;
      m_addr <= '0;
      m_wd   <= '0;
      for (int i = 0; i < 2; i++) begin
        m_rd[i]  <= '0;
        m_rv[i]  <= 0;
        m_err[i] <= 0;
      end
    end else begin
      if (!m_act) begin
        if (bus.req0_valid || bus.req1_valid) begin
          g = win();
          m_act  <= 1;
          m_resp <= 0;
          m_g    <= g;
          m_own  <= g;
          m_last <= g;
          m_tacc <= cyc + 1;
          m_cmd  <= g ? bus.req1_command : bus.req0_command;
          m_addr <= g ? bus.req1_address : bus.req0_address;
          m_wd   <= g ? bus.req1_wr_data : bus.req0_wr_data;
        end
      end else if (m_resp) begin
        if (m_g ? bus.rsp1_ready : bus.rsp0_ready) begin
          m_rv[m_g] <= 0;
          m_act     <= 0;
        end
      end else if (cyc >= m_tacc + 1) begin
        if (bus.xspi_done) begin
          m_rv[m_g]  <= 1;
          m_rd[m_g]  <= bus.xspi_rd_data;
          m_err[m_g] <= 0;
          m_resp     <= 1;
        end
`ifdef XSPI_ARB_TIMEOUT_EN
        else if (cyc - (m_tacc + 1) == longint'(TO - 1)) begin
          m_rv[m_g]  <= 1;
          m_rd[m_g]  <= '0;
          m_err[m_g] <= 1;
          m_resp     <= 1;
        end
`endif
      end
      cyc <= cyc + 1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    bit w;
    w = win();
    chk("ready0", bus.req0_ready,
        !m_act && bus.req0_valid && !w);
    chk("ready1", bus.req1_ready,
        !m_act && bus.req1_valid && w);
    chk("busy", busy, m_act);
    chk("owner", owner, m_own);
    chk("start", bus.xspi_start,
        m_act && (cyc == m_tacc));
    chk("cmd", bus.xspi_command, m_cmd);
    chk("addr", bus.xspi_address, m_addr);
    chk("wdata", bus.xspi_wr_data, m_wd);
    chk("rsp0_valid", bus.rsp0_valid, m_rv[0]);
    chk("rsp0_data", bus.rsp0_rd_data, m_rd[0]);
    chk("rsp0_err", bus.rsp0_err, m_err[0]);
    chk("rsp1_valid", bus.rsp1_valid, m_rv[1]);
    chk("rsp1_data", bus.rsp1_rd_data, m_rd[1]);
    chk("rsp1_err", bus.rsp1_err, m_err[1]);
    rdy0_s = bus.req0_ready;
    rdy1_s = bus.req1_ready;
    if (bus.xspi_start === 1'b1) n_start++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    rst_n = 0;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.rsp0_ready = 0;
    bus.rsp1_ready = 0;
    bus.xspi_done  = 0;
    step();
    rst_n = 1;
  endtask

  task automatic wait_rsp0(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid === 1'b1) ok = 1;
    end
    chk("wait_rsp0", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1;
    end
    chk("wait_idle", ok, 1);
  endtask

  function automatic logic [7:0] pick_cmd();
    case ($urandom_range(0, 2))
      0: return 8'hFF;
      1: return 8'hA5;
      default: return 8'($urandom());
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int s0, ng, k;
    bit found, pend;
    int gq [4];
    int oq [$];

    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_command = 0; bus.req1_command = 0;
    bus.req0_address = 0; bus.req1_address = 0;
    bus.req0_wr_data = 0; bus.req1_wr_data = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    bus.xspi_done = 0; bus.xspi_rd_data = 0;
    cyc = 0;

    #2 rst_n = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_start", bus.xspi_start, 0);
    chk("rst_addr", bus.xspi_address, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_data", bus.rsp1_rd_data, 0);
    step();
    rst_n = 1;

    // single read
    step();
    bus.req0_valid   = 1;
    bus.req0_command = 8'hFF;
    bus.req0_address = 48'h0000_0000_0010;
    bus.req0_wr_data = 64'h0;
    @(negedge clk);
    chk("rd_ready0", bus.req0_ready, 1);
    s0 = n_start;
    step();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("rd_start", bus.xspi_start, 1);
    chk("rd_cmd", bus.xspi_command, 8'hFF);
    chk("rd_addr", bus.xspi_address, 48'h10);
    repeat (RD_DLY) step();
    bus.xspi_done    = 1;
    bus.xspi_rd_data = 64'h1122334455667788;
    step();
    bus.xspi_done = 0;
    @(negedge clk);
    chk("rd_rsp_valid", bus.rsp0_valid, 1);
    chk("rd_rsp_data", bus.rsp0_rd_data, 64'h1122334455667788);
    chk("rd_rsp_err", bus.rsp0_err, 0);
    step();
    bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0;
    @(negedge clk);
    chk("rd_done_valid", bus.rsp0_valid, 0);
    chk("rd_done_busy", busy, 0);
    chk("rd_hold_data", bus.rsp0_rd_data, 64'h1122334455667788);
    chk("rd_one_start", n_start - s0, 1);

    // tie from reset, then round robin
    pulse_reset();
    bus.rsp0_ready = 1;
    bus.rsp1_ready = 1;
    bus.xspi_done  = 1;
    bus.xspi_rd_data = 64'hCAFE_0000_0000_0001;
    step();
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    bus.req1_command = 8'hA5;
    bus.req1_address = 48'h0000_1234_5678;
    bus.req1_wr_data = 64'h0BAD_F00D_0000_0042;
    ng = 0;
    pend = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (pend) begin
        oq.push_back(int'(owner));
        pend = 0;
      end
      if (bus.req0_ready === 1'b1) begin
        gq[ng] = 0; ng++; pend = 1;
      end else if (bus.req1_ready === 1'b1) begin
        gq[ng] = 1; ng++; pend = 1;
      end
    end
    step();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("rr_count", ng, 4);
    chk("rr_g0", gq[0], 0);
    chk("rr_g1", gq[1], 1);
    chk("rr_g2", gq[2], 0);
    chk("rr_g3", gq[3], 1);
    chk("rr_nown", oq.size() >= 2, 1);
    if (oq.size() >= 2) begin
      chk("rr_owner0", oq[0], 0);
      chk("rr_owner1", oq[1], 1);
    end
    wait_idle();

    // response backpressure blocks the other requester
    pulse_reset();
    bus.xspi_done    = 1;
    bus.xspi_rd_data = 64'hDEAD_BEEF_0000_0001;
    step();
    bus.req0_valid = 1;
    step();
    bus.req0_valid = 0;
    bus.req1_valid = 1;
    wait_rsp0(ok);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp0_held", bus.rsp0_valid, 1);
      chk("bp_req1_wait", bus.req1_ready, 0);
      @(negedge clk);
    end
    step();
    bus.rsp0_ready = 1;
    @(negedge clk);
    chk("bp_hs_req1", bus.req1_ready, 0);
    step();
    bus.rsp0_ready = 0;
    @(negedge clk);
    chk("bp_rsp0_clr", bus.rsp0_valid, 0);
    chk("bp_req1_go", bus.req1_ready, 1);
    step();
    bus.req1_valid = 0;
    bus.rsp1_ready = 1;
    wait_idle();
    step();
    bus.rsp1_ready = 0;
    bus.xspi_done  = 0;

    // controller never answers
    step();
    bus.req0_valid = 1;
    step();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("to_start", bus.xspi_start, 1);
    k = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      k++;
      if (bus.rsp0_valid === 1'b1) found = 1;
    end
`ifdef XSPI_ARB_TIMEOUT_EN
    chk("to_found", found, 1);
    chk("to_latency", k, 9);
    chk("to_err", bus.rsp0_err, 1);
    chk("to_data", bus.rsp0_rd_data, 0);
    step();
    bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0;
`else
    chk("nto_valid", found, 0);
    chk("nto_busy", busy, 1);
`endif

    // reset while waiting on the controller
    pulse_reset();
    step();
    bus.req0_valid = 1;
    step();
    bus.req0_valid = 0;
    step();
    step();
    step();
    rst_n = 0;
    @(negedge clk);
    chk("rw_busy", busy, 0);
    chk("rw_start", bus.xspi_start, 0);
    chk("rw_rsp0", bus.rsp0_valid, 0);
    step();
    rst_n = 1;
    bus.xspi_done = 1;
    repeat (8) begin
      @(negedge clk);
      chk("rw_no_rsp0", bus.rsp0_valid, 0);
      chk("rw_idle", busy, 0);
    end
    step();
    bus.xspi_done = 0;

    // randomized traffic
    pulse_reset();
    for (int c = 0; c < 4000; c++) begin
      step();
      if (!rst_n)
        rst_n = 1;
      else if ($urandom_range(0, 599) == 0)
        rst_n = 0;

      if (bus.req0_valid && rdy0_s)
        bus.req0_valid = 0;
      else if (bus.req0_valid && $urandom_range(0, 39) == 0)
        bus.req0_valid = 0;
      else if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
        bus.req0_valid   = 1;
        bus.req0_command = pick_cmd();
        bus.req0_address = 48'({$urandom(), $urandom()});
        bus.req0_wr_data = {$urandom(), $urandom()};
      end

      if (bus.req1_valid && rdy1_s)
        bus.req1_valid = 0;
      else if (bus.req1_valid && $urandom_range(0, 39) == 0)
        bus.req1_valid = 0;
      else if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
        bus.req1_valid   = 1;
        bus.req1_command = pick_cmd();
        bus.req1_address = 48'({$urandom(), $urandom()});
        bus.req1_wr_data = {$urandom(), $urandom()};
      end

      bus.xspi_done    = ($urandom_range(0, 4) == 0);
      bus.xspi_rd_data = {$urandom(), $urandom()};
      bus.rsp0_ready   = $urandom_range(0, 1) == 1;
      bus.rsp1_ready   = $urandom_range(0, 1) == 1;
    end

    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/xspi_req_arbiter.md
XSPI_REQ_ARBITER -- requirements
Module: xspi_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning max cycles waited for xspi_done before abort (used only with XSPI_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-004 SHALL have, per requester N in {0,1}: reqN_valid in 1 request pending; reqN_ready out 1 request accepted; reqN_command in 8; reqN_address in 48; reqN_wr_data in 64.
REQ-005 SHALL have, per N: rspN_valid out 1 response available; rspN_ready in 1 response consumed; rspN_rd_data out 64; rspN_err out 1 timeout flag.
REQ-006 SHALL have controller-side ports: xspi_start out 1; xspi_command out 8; xspi_address out 48; xspi_wr_data out 64; xspi_rd_data in 64; xspi_done in 1.
REQ-007 SHALL have status ports: busy out 1 (state != IDLE); owner out 1 (current/last granted requester).

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 IDLE: if no reqN_valid, stay; else select grant and drive reqG_ready=1 combinationally for that requester only, same cycle.
REQ-010 Arbitration: single valid wins; both valid -> requester != last_grant wins (round robin); last_grant resets to 1 so requester 0 wins first tie.
REQ-011 On reqG_valid & reqG_ready: latch command/address/wr_data into xspi_command/xspi_address/xspi_wr_data registers, set owner=G, last_grant=G, go ISSUE.
REQ-012 ISSUE: xspi_start=1 for exactly one cycle, go WAIT; xspi_start SHALL be 0 in every other state.
REQ-013 xspi_command/xspi_address/xspi_wr_data SHALL hold stable from latch until return to IDLE.
REQ-014 WAIT: on xspi_done=1 capture xspi_rd_data into rspG_rd_data, rspG_err=0, go RESP; xspi_done in any other state ignored.
REQ-015 RESP: rspG_valid=1 held until rspG_ready=1; on that cycle clear rspG_valid, go IDLE; the other requester's rsp outputs unchanged.
REQ-016 Command byte passed through unmodified; no decoding (0xFF read, 0xA5 write, others handled by controller).
REQ-017 Accept-to-start latency: 1 cycle; done-to-rspG_valid latency: 1 cycle; minimum IDLE->IDLE transaction: 4 cycles + controller time.
REQ-018 A request arriving during busy SHALL wait (reqN_ready=0); requester holds reqN_valid and payload until accepted.
REQ-019 rspN_rd_data/rspN_err SHALL hold last value until overwritten by the next response to that requester.
REQ-020 Requester deasserting reqN_valid before accept SHALL leave no side effect.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, xspi_start 0, xspi_command 0, xspi_address 0, xspi_wr_data 0, all rspN_valid 0, rspN_rd_data 0, rspN_err 0, busy 0, owner 0, last_grant 1, timeout counter 0.
REQ-022 Reset mid-transaction SHALL abandon it with no response generated; requester must reissue.

Configuration
REQ-023 Macro XSPI_ARB_TIMEOUT_EN defined: 16-bit counter clears on entering WAIT, increments each WAIT cycle; when count reaches TIMEOUT_CYCLES-1 without xspi_done, go RESP with rspG_rd_data=0, rspG_err=1.
REQ-024 xspi_done and timeout in the same cycle: xspi_done wins (err=0, data captured).
REQ-025 Macro undefined: no counter, WAIT waits indefinitely, rspN_err tied 0.

Verification
REQ-026 Single read: req0 cmd 0xFF addr 0x0000_0000_0010, done after 20 cycles with rd_data 0x1122334455667788 -> one xspi_start pulse, rsp0_valid with rsp0_rd_data 0x1122334455667788, rsp0_err 0.
REQ-027 Simultaneous req0/req1 from reset -> req0 granted first, req1 granted on next IDLE; owner 0 then 1.
REQ-028 Both continuously valid for 4 transactions -> grant order 0,1,0,1.
REQ-029 rsp0_ready held low 10 cycles -> rsp0_valid held, req1 not accepted until after rsp0 handshake.
REQ-030 XSPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, xspi_done never asserted -> RESP after 8 WAIT cycles, rsp_err 1, rsp_rd_data 0; macro undefined -> busy remains 1.
REQ-031 rst_n low during WAIT -> busy 0, xspi_start 0, no rspN_valid afterwards.
